// File: rtl/alu_control_unit.sv
// alu_control_unit: ALU operation decode for the single-cycle MIPS core plus an
// iterative multiply/divide unit (shift-add / restoring shift-subtract) with
// HI/LO registers and a PC stall while an operation is in flight.
// Optional macro SIGNED_MULDIV_EN adds signed mult (011000) and div (011010).
module alu_control_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             valid,
   input  logic [1:0]       aluOp,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rsData,
   input  logic [WIDTH-1:0] rtData,
   output logic [3:0]       operation,
   output logic             illegal,
   output logic [1:0]       hiLoSel,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_rem;      // multiply: product high half; divide: partial remainder
   logic [WIDTH-1:0]   r_quo;      // multiply: multiplier/product low half; divide: dividend/quotient
   logic [WIDTH-1:0]   r_b;        // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   r_a;        // original dividend, returned in HI on divide by zero
   logic               r_div;
   logic               r_b_zero;
   logic               r_neg_q;    // quotient/product must be negated
   logic               r_neg_r;    // remainder must be negated
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_illegal_raw;
   logic               w_muldiv;
   logic               w_is_div;
   logic               w_signed;
   logic               w_start;
   logic               w_last;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_hi_res;
   logic [WIDTH-1:0]   w_lo_res;

   // Decode aluOp/funct into the ALU code, HI/LO select and mul/div request.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      operation     = 4'b0010;
      hiLoSel       = 2'b00;
      w_illegal_raw = 1'b0;
      w_muldiv      = 1'b0;
      w_is_div      = 1'b0;
      w_signed      = 1'b0;
      case (aluOp)
         2'b00: operation = 4'b0010;
         2'b01: operation = 4'b0110;
         2'b11: operation = 4'b0001;
         default: begin
            case (funct)
               6'b100000, 6'b100001: operation = 4'b0010;
               6'b100010, 6'b100011: operation = 4'b0110;
               6'b100100:            operation = 4'b0000;
               6'b100101:            operation = 4'b0001;
               6'b100111:            operation = 4'b1100;
               6'b101010:            operation = 4'b0111;
               6'b010000:            hiLoSel   = 2'b01;
               6'b010010:            hiLoSel   = 2'b10;
               6'b011001:            w_muldiv  = 1'b1;
               6'b011011: begin
                  w_muldiv = 1'b1;
                  w_is_div = 1'b1;
               end
`ifdef SIGNED_MULDIV_EN
               6'b011000: begin
                  w_muldiv = 1'b1;
                  w_signed = 1'b1;
               end
               6'b011010: begin
                  w_muldiv = 1'b1;
                  w_is_div = 1'b1;
                  w_signed = 1'b1;
               end
`endif
               default:              w_illegal_raw = 1'b1;
            endcase
         end
      endcase
   end

   assign illegal = valid & w_illegal_raw;
   assign w_start = valid & w_muldiv;
   assign w_last  = (r_count == CNT_W'(WIDTH - 1));

   // Operand magnitudes; signs are reapplied when the result is written.
   assign w_a_neg = w_signed & rsData[WIDTH-1];
   assign w_b_neg = w_signed & rtData[WIDTH-1];
   assign w_a_mag = w_a_neg ? -rsData : rsData;
   assign w_b_mag = w_b_neg ? -rtData : rtData;

   // One iteration of shift-add multiply or restoring shift-subtract divide.
   always_comb begin
      w_sum     = {1'b0, r_rem} + {1'b0, (r_quo[0] ? r_b : '0)};
      w_shift   = {r_rem, r_quo[WIDTH-1]};
      w_ge      = (w_shift >= {1'b0, r_b});
      w_diff    = w_shift[WIDTH-1:0] - r_b;
      w_rem_nxt = w_sum[WIDTH:1];
      w_quo_nxt = {w_sum[0], r_quo[WIDTH-1:1]};
      if (r_div) begin
         w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
         w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
      end
   end

   // Sign fix-up and divide-by-zero override for the value written to HI/LO.
   always_comb begin
      w_prod   = {w_rem_nxt, w_quo_nxt};
      w_hi_res = r_neg_q ? w_prod[2*WIDTH-1:WIDTH] : w_rem_nxt;
      w_lo_res = w_quo_nxt;
      if (r_neg_q) begin
         w_prod = -{w_rem_nxt, w_quo_nxt};
      end
      if (r_div) begin
         w_lo_res = r_neg_q ? -w_quo_nxt : w_quo_nxt;
         w_hi_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;
         if (r_b_zero) begin
            w_lo_res = '1;
            w_hi_res = r_a;
         end
      end else begin
         w_hi_res = w_prod[2*WIDTH-1:WIDTH];
         w_lo_res = w_prod[WIDTH-1:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstN) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      if (!rstN) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and stall; stall is forced low while reset is asserted.
   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               stall       = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            stall = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
      stall = stall & rstN;
   end

   // Operand capture, iteration, and the single HI/LO write at the last step.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_count  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_b      <= '0;
         r_a      <= '0;
         r_div    <= 1'b0;
         r_b_zero <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (r_state == IDLE && w_start) begin
         r_count  <= '0;
         r_rem    <= '0;
         r_quo    <= w_a_mag;
         r_b      <= w_b_mag;
         r_a      <= rsData;
         r_div    <= w_is_div;
         r_b_zero <= (rtData == '0);
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
      end else if (r_state == RUN) begin
         r_rem   <= w_rem_nxt;
         r_quo   <= w_quo_nxt;
         r_count <= r_count + CNT_W'(1);
         if (w_last) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
         end
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule
